alu_ctrl_pipe: RTL and testbench



---
 rtl/alu_ctrl_pkg.sv | 37 +++
 rtl/alu_ctrl_decode.sv | 90 +++++++++
 rtl/alu_ctrl_pipe.sv | 155 +++++++++++++++
 tb/tb_alu_ctrl_pipe.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU-control stage: opcodes, ALU operation codes, FSM states.
package alu_ctrl_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  // M ops are this base OR'd with funct3 (MUL 10000 .. REMU 10111).
  localparam logic [4:0] ALU_M_BASE = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HOLD = 2'b01,
    ST_BUSY = 2'b10
  } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode/funct3/funct7 -> ALU code decoder. RV32M_EN enables M-extension decode.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W = 5
) (
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  output logic [CTRL_W-1:0] code_o,
  output logic              illegal_o,
  output logic              is_mul_o,
  output logic              is_div_o
);

  logic [3:0] base_s;
  logic       illegal_s;
  logic       is_m_s;

  // Decode table; illegal encodings keep the ADD code.
  always_comb begin
    base_s    = ALU_ADD;
    illegal_s = 1'b0;
    is_m_s    = 1'b0;
    case (opcode)
      OPC_R: begin
        case (funct7)
          F7_BASE: begin
            case (funct3)
              3'b000:  base_s = ALU_ADD;
              3'b001:  base_s = ALU_SLL;
              3'b010:  base_s = ALU_SLT;
              3'b011:  base_s = ALU_SLTU;
              3'b100:  base_s = ALU_XOR;
              3'b101:  base_s = ALU_SRL;
              3'b110:  base_s = ALU_OR;
              3'b111:  base_s = ALU_AND;
              default: base_s = ALU_ADD;
            endcase
          end
          F7_ALT: begin
            case (funct3)
              3'b000:  base_s = ALU_SUB;
              3'b101:  base_s = ALU_SRA;
              default: illegal_s = 1'b1;
            endcase
          end
`ifdef RV32M_EN
          F7_MULDIV: is_m_s = 1'b1;
`endif
          default: illegal_s = 1'b1;
        endcase
      end
      OPC_I: begin
        case (funct3)
          3'b000:  base_s = ALU_ADD;
          3'b010:  base_s = ALU_SLT;
          3'b011:  base_s = ALU_SLTU;
          3'b100:  base_s = ALU_XOR;
          3'b110:  base_s = ALU_OR;
          3'b111:  base_s = ALU_AND;
          3'b001: begin
            if (funct7 == F7_BASE) base_s = ALU_SLL;
            else                   illegal_s = 1'b1;
          end
          3'b101: begin
            if (funct7 == F7_BASE)     base_s = ALU_SRL;
            else if (funct7 == F7_ALT) base_s = ALU_SRA;
            else                       illegal_s = 1'b1;
          end
          default: illegal_s = 1'b1;
        endcase
      end
      OPC_LOAD, OPC_STORE, OPC_JALR, OPC_AUIPC, OPC_LUI: base_s = ALU_ADD;
      OPC_BRANCH: base_s = ALU_SUB;
      default:    illegal_s = 1'b1;
    endcase
  end

  // Final code selection; the M code is only reachable when the extension is built in.
  always_comb begin
    if (is_m_s) code_o = CTRL_W'(ALU_M_BASE | {2'b00, funct3});
    else        code_o = CTRL_W'(base_s);
  end

  assign illegal_o = illegal_s;
  assign is_mul_o  = is_m_s & ~funct3[2];
  assign is_div_o  = is_m_s &  funct3[2];

endmodule

// File: rtl/alu_ctrl_pipe.sv
// Registered, handshaked ALU-control stage between ID and EX.
// RV32M_EN adds M-op decode and the multi-cycle BUSY state with its latency counter.
module alu_ctrl_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W  = 5,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_alu_ctrl,
  output logic              out_illegal,
  output logic              out_multicycle
);

  if (CTRL_W < 4) begin : g_chk_w
    $error("alu_ctrl_pipe: CTRL_W must be at least 4");
  end
  if (MUL_LAT < 1 || DIV_LAT < 1) begin : g_chk_lat
    $error("alu_ctrl_pipe: MUL_LAT and DIV_LAT must be at least 1");
  end

  logic [CTRL_W-1:0] dec_code_s;
  logic              dec_illegal_s;
  logic              is_mul_s;
  logic              is_div_s;

  alu_ctrl_decode #(.CTRL_W(CTRL_W)) u_decode (
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .code_o    (dec_code_s),
    .illegal_o (dec_illegal_s),
    .is_mul_o  (is_mul_s),
    .is_div_o  (is_div_s)
  );

  state_e            state_q, state_d;
  logic              out_valid_q;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              illegal_q, illegal_d;
  logic              accept_s;

  assign in_ready = rst_n && !flush &&
                    ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready));
  assign accept_s = in_valid && in_ready;

`ifdef RV32M_EN
  if (CTRL_W < 5) begin : g_chk_m
    $error("alu_ctrl_pipe: CTRL_W must be at least 5 with RV32M_EN");
  end

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             multi_q, multi_d;
  logic [31:0]      lat_s;

  assign lat_s = is_mul_s ? 32'(MUL_LAT) : 32'(DIV_LAT);
`else
  logic unused_m_s;
  assign unused_m_s = is_mul_s | is_div_s;
`endif

  // Next-state, counter and output-register load logic; flush overrides everything.
  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    illegal_d = illegal_q;
`ifdef RV32M_EN
    cnt_d     = cnt_q;
    multi_d   = multi_q;
`endif
    if (flush) begin
      state_d = ST_IDLE;
`ifdef RV32M_EN
      cnt_d   = {CNT_W{1'b0}};
`endif
    end else if (accept_s) begin
      ctrl_d    = dec_code_s;
      illegal_d = dec_illegal_s;
      state_d   = ST_HOLD;
`ifdef RV32M_EN
      multi_d   = is_mul_s | is_div_s;
      if ((is_mul_s | is_div_s) && (lat_s > 32'd1)) begin
        state_d = ST_BUSY;
        cnt_d   = CNT_W'(lat_s - 32'd2);
      end else begin
        cnt_d   = {CNT_W{1'b0}};
      end
`endif
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_HOLD: begin
          if (out_ready) state_d = ST_IDLE;
          else           state_d = ST_HOLD;
        end
`ifdef RV32M_EN
        ST_BUSY: begin
          if (cnt_q == {CNT_W{1'b0}}) state_d = ST_HOLD;
          else                        cnt_d   = cnt_q - CNT_W'(1'b1);
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      ctrl_q      <= {CTRL_W{1'b0}};
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d == ST_HOLD);
      ctrl_q      <= ctrl_d;
      illegal_q   <= illegal_d;
    end
  end

`ifdef RV32M_EN
  // Latency counter and multi-cycle flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= {CNT_W{1'b0}};
      multi_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      multi_q <= multi_d;
    end
  end
  assign out_multicycle = multi_q;
`else
  assign out_multicycle = 1'b0;
`endif

  assign out_valid    = out_valid_q;
  assign out_alu_ctrl = ctrl_q;
  assign out_illegal  = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Self-checking bench for alu_ctrl_pipe: decode vector table plus handshake/flush/reset sequences.
`timescale 1ns/1ps
module tb_alu_ctrl_pipe;

  localparam int CTRL_W  = 5;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_alu_ctrl;
  logic              out_illegal;
  logic              out_multicycle;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] ctrl;
    logic       ill;
  } vec_t;

  vec_t vecs[$];

  alu_ctrl_pipe #(.CTRL_W(CTRL_W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .opcode         (opcode),
    .funct3         (funct3),
    .funct7         (funct7),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_alu_ctrl   (out_alu_ctrl),
    .out_illegal    (out_illegal),
    .out_multicycle (out_multicycle)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    in_valid = 1'b1;
    opcode   = op;
    funct3   = f3;
    funct7   = f7;
  endtask

  initial begin
    int   cnt;
    int   low;
    logic seen;

    // opcode, funct3, funct7, expected code, expected illegal
    vecs.push_back('{7'b0110011, 3'b000, 7'b0100000, 5'b00001, 1'b0}); // SUB
    vecs.push_back('{7'b0010011, 3'b101, 7'b0100000, 5'b01001, 1'b0}); // SRAI
    vecs.push_back('{7'b0010011, 3'b010, 7'b1010101, 5'b00101, 1'b0}); // SLTI
    vecs.push_back('{7'b0110011, 3'b001, 7'b0100000, 5'b00000, 1'b1}); // bad alt funct3
    vecs.push_back('{7'b1111111, 3'b000, 7'b0000000, 5'b00000, 1'b1}); // bad opcode
    vecs.push_back('{7'b0110011, 3'b001, 7'b0000000, 5'b00111, 1'b0}); // SLL
    vecs.push_back('{7'b0110011, 3'b111, 7'b0000000, 5'b00010, 1'b0}); // AND
    vecs.push_back('{7'b0110011, 3'b011, 7'b0000000, 5'b00110, 1'b0}); // SLTU
    vecs.push_back('{7'b0110011, 3'b100, 7'b0000000, 5'b00100, 1'b0}); // XOR
    vecs.push_back('{7'b0110011, 3'b110, 7'b0000000, 5'b00011, 1'b0}); // OR
    vecs.push_back('{7'b0110011, 3'b101, 7'b0000000, 5'b01000, 1'b0}); // SRL
    vecs.push_back('{7'b0110011, 3'b101, 7'b0100000, 5'b01001, 1'b0}); // SRA
    vecs.push_back('{7'b0110011, 3'b000, 7'b1000000, 5'b00000, 1'b1}); // bad funct7
    vecs.push_back('{7'b0010011, 3'b000, 7'b1111111, 5'b00000, 1'b0}); // ADDI ignores funct7
    vecs.push_back('{7'b0010011, 3'b001, 7'b0100000, 5'b00000, 1'b1}); // SLLI bad funct7
    vecs.push_back('{7'b0010011, 3'b101, 7'b0000000, 5'b01000, 1'b0}); // SRLI
    vecs.push_back('{7'b0010011, 3'b101, 7'b0000001, 5'b00000, 1'b1}); // shift bad funct7
    vecs.push_back('{7'b0010011, 3'b111, 7'b0000000, 5'b00010, 1'b0}); // ANDI
    vecs.push_back('{7'b1100011, 3'b001, 7'b0000000, 5'b00001, 1'b0}); // branch
    vecs.push_back('{7'b0000011, 3'b010, 7'b0000000, 5'b00000, 1'b0}); // load
    vecs.push_back('{7'b0100011, 3'b010, 7'b0000000, 5'b00000, 1'b0}); // store
    vecs.push_back('{7'b1100111, 3'b000, 7'b0000000, 5'b00000, 1'b0}); // jalr
    vecs.push_back('{7'b0010111, 3'b000, 7'b0000000, 5'b00000, 1'b0}); // auipc
    vecs.push_back('{7'b0110111, 3'b000, 7'b0000000, 5'b00000, 1'b0}); // lui
    vecs.push_back('{7'b1101111, 3'b000, 7'b0000000, 5'b00000, 1'b1}); // jal not decoded
`ifndef RV32M_EN
    vecs.push_back('{7'b0110011, 3'b000, 7'b0000001, 5'b00000, 1'b1}); // M op without extension
`endif

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    opcode = 7'b0000000; funct3 = 3'b000; funct7 = 7'b0000000;
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_ctrl", out_alu_ctrl, 5'b00000);
    check("rst_illegal", out_illegal, 1'b0);
    check("rst_multi", out_multicycle, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("idle_in_ready", in_ready, 1'b1);

    // Back-to-back table with out_ready held high.
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].f3, vecs[i].f7);
      check($sformatf("v%0d_in_ready", i), in_ready, 1'b1);
      step();
      check($sformatf("v%0d_valid", i), out_valid, 1'b1);
      check($sformatf("v%0d_ctrl", i), out_alu_ctrl, vecs[i].ctrl);
      check($sformatf("v%0d_illegal", i), out_illegal, vecs[i].ill);
      check($sformatf("v%0d_multi", i), out_multicycle, 1'b0);
    end
    in_valid = 1'b0;
    step();
    check("drain_valid", out_valid, 1'b0);

    // out_ready stall for 3 cycles, then release with a waiting instruction.
    out_ready = 1'b0;
    drive(7'b0110011, 3'b100, 7'b0000000);
    step();
    drive(7'b0110011, 3'b110, 7'b0000000);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall%0d_valid", k), out_valid, 1'b1);
      check($sformatf("stall%0d_ctrl", k), out_alu_ctrl, 5'b00100);
      check($sformatf("stall%0d_in_ready", k), in_ready, 1'b0);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    check("release_valid", out_valid, 1'b1);
    check("release_ctrl", out_alu_ctrl, 5'b00011);
    step();
    check("release_drain", out_valid, 1'b0);

    // Flush while holding; a concurrent request must not be accepted.
    out_ready = 1'b0;
    drive(7'b0110011, 3'b000, 7'b0100000);
    step();
    drive(7'b0110011, 3'b100, 7'b0000000);
    check("hold_valid", out_valid, 1'b1);
    flush = 1'b1;
    #1;
    check("flush_in_ready", in_ready, 1'b0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", out_valid, 1'b0);
    check("flush_ctrl_kept", out_alu_ctrl, 5'b00001);
    step();
    check("flush_stays_idle", out_valid, 1'b0);
    check("flush_idle_ready", in_ready, 1'b1);

    // Asynchronous reset mid-HOLD.
    drive(7'b0110011, 3'b111, 7'b0000000);
    step();
    in_valid = 1'b0;
    check("hold2_ctrl", out_alu_ctrl, 5'b00010);
    rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_ctrl", out_alu_ctrl, 5'b00000);
    check("arst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check("arst_no_stale", out_valid, 1'b0);

`ifdef RV32M_EN
    // DIV: BUSY for DIV_LAT-1 cycles after the accept edge.
    drive(7'b0110011, 3'b100, 7'b0000001);
    step();
    in_valid = 1'b0;
    cnt = 0; low = 0;
    while (!out_valid && cnt < 40) begin
      if (!in_ready) low++;
      step();
      cnt++;
    end
    check("div_latency", cnt, DIV_LAT - 1);
    check("div_ready_low", low, DIV_LAT - 1);
    check("div_ctrl", out_alu_ctrl, 5'b10100);
    check("div_multi", out_multicycle, 1'b1);
    check("div_illegal", out_illegal, 1'b0);
    step();
    check("div_drain", out_valid, 1'b0);

    // MULHU with latency 2.
    drive(7'b0110011, 3'b011, 7'b0000001);
    step();
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      step();
      cnt++;
    end
    check("mul_latency", cnt, MUL_LAT - 1);
    check("mul_ctrl", out_alu_ctrl, 5'b10011);
    step();

    // Flush during BUSY: no result may ever appear.
    drive(7'b0110011, 3'b111, 7'b0000001);
    step();
    in_valid = 1'b0;
    repeat (4) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("busy_flush_valid", out_valid, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      seen = seen | out_valid;
      step();
    end
    check("busy_flush_no_stale", seen, 1'b0);
    check("busy_flush_ready", in_ready, 1'b1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
